// File: rtl/cube_root_arb_pkg.sv
// cube_root_arb_pkg: shared FSM state type and parameter defaults for the cube-root arbiter.
package cube_root_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int TIMEOUT_CYCLES_DEF = 64;
endpackage

// File: rtl/cube_root_arbiter_rr_grant.sv
// rr_grant: combinational round-robin pick; the search starts at ptr_i and wraps.
module rr_grant
  import cube_root_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);
  logic found;
  always_comb begin
    grant_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[(int'(ptr_i) + k) % N]) begin
        grant_o[(int'(ptr_i) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cube_root_arbiter.sv
// cube_root_arbiter: round-robin sharing of one cube-root core among NUM_REQ requesters.
// Define CUBE_ROOT_ARB_TIMEOUT_EN to compile in the WAIT-state watchdog.
module cube_root_arbiter
  import cube_root_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_operand,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_result
);
  localparam int PW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("cube_root_arbiter: illegal parameters");
  end
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0] owner_q, owner_d, grant;
  logic [DATA_W-1:0] operand_q, operand_d, data_q, data_d;
  int gidx;
  rr_grant #(.N(NUM_REQ)) u_rr_grant (.req_i(req_valid), .ptr_i(ptr_q), .grant_o(grant));
  always_comb begin
    gidx = 0;
    for (int i = 0; i < NUM_REQ; i++) if (grant[i]) gidx = i;
  end
`ifdef CUBE_ROOT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    operand_d = operand_q;
    data_d = data_q;
`ifdef CUBE_ROOT_ARB_TIMEOUT_EN
    err_d = err_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = ISSUE;
        ptr_d = (gidx == NUM_REQ - 1) ? '0 : PW'(gidx + 1);
        owner_d = grant;
        operand_d = req_data[gidx*DATA_W +: DATA_W];
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef CUBE_ROOT_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT: if (core_done) begin
        state_d = RESP;
        data_d = core_result;
`ifdef CUBE_ROOT_ARB_TIMEOUT_EN
        err_d = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = RESP;
        data_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      operand_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      operand_q <= operand_d;
      data_q <= data_d;
    end
  end
`ifdef CUBE_ROOT_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign resp_err = (state_q == RESP) && err_q;
`else
  assign resp_err = 1'b0;
`endif
  // Gated by reset so nothing is accepted while reset is held low.
  assign req_ready = (state_q == IDLE && reset) ? grant : '0;
  assign resp_valid = (state_q == RESP) ? owner_q : '0;
  assign resp_data = data_q;
  assign core_start = state_q == ISSUE;
  assign core_operand = operand_q;
endmodule

// File: tb/tb_cube_root_arbiter.sv
// tb_cube_root_arbiter: directed stimulus with grant/response scoreboards for cube_root_arbiter.
module tb_cube_root_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req_valid, req_ready, resp_valid;
  logic [N*W-1:0] req_data;
  logic [W-1:0] resp_data, core_operand, core_result;
  logic resp_err, core_start, core_done;

  cube_root_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .core_start(core_start), .core_operand(core_operand),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] owner;
    logic [W-1:0] data;
    logic err;
    int lat;
  } resp_t;
  resp_t exp_resp[$];
  int exp_grant[$];
  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, n_grants = 0, done_n = 0, stray_n = 0;
  int core_lat = 20;
  bit core_hang = 1'b0;
  logic [N-1:0] auto_drop = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] cbrt_of(input logic [W-1:0] x);
    case (x[31:16])
      16'd8:    return 32'h0002_0000;
      16'd27:   return 32'h0003_0000;
      16'd64:   return 32'h0004_0000;
      16'd125:  return 32'h0005_0000;
      16'd1000: return 32'h000A_0000;
      default:  return 32'h0000_0000;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: done arrives core_lat cycles after the core_start cycle; it ignores reset.
  initial begin
    logic [W-1:0] op;
    int seen;
    seen = 0;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_start && !core_hang) begin
        op = core_operand;
        repeat (core_lat) @(posedge clk);
        #1 core_done = 1'b1; core_result = cbrt_of(op);
        @(posedge clk);
        #1 core_done = 1'b0; core_result = '0;
        done_n++;
      end else if (stray_n != seen) begin
        seen = stray_n;
        @(posedge clk);
        #1 core_done = 1'b1; core_result = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 core_done = 1'b0; core_result = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (req_ready != '0) begin
      check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
      check("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
      if ((req_valid & req_ready) != '0) begin
        n_grants++;
        acc_cyc = cyc;
        if (exp_grant.size() == 0) check("unexpected_grant", 64'(req_ready), 64'd0);
        else check("grant", 64'(req_ready), 64'(1) << exp_grant.pop_front());
      end
    end
  end

  always @(negedge clk) begin : resp_mon
    resp_t e;
    if (resp_valid != '0) begin
      if (exp_resp.size() == 0) check("unexpected_resp", 64'(resp_valid), 64'd0);
      else begin
        e = exp_resp.pop_front();
        check("resp_owner", 64'(resp_valid), 64'(e.owner));
        check("resp_data", 64'(resp_data), 64'(e.data));
        check("resp_err", 64'(resp_err), 64'(e.err));
        if (e.lat > 0) check("resp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
      end
    end
  end

  task automatic tick();
    logic [N-1:0] x;
    @(negedge clk);
    x = req_valid & req_ready;
    @(posedge clk);
    #1 req_valid = req_valid & ~(x & auto_drop);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic push(input int g, input logic [W-1:0] d, input logic e, input int lat);
    resp_t r;
    r.owner = N'(1) << g;
    r.data = d;
    r.err = e;
    r.lat = lat;
    exp_grant.push_back(g);
    exp_resp.push_back(r);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_resp.size() != 0 || exp_grant.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(exp_resp.size() + exp_grant.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] rd, co;
    int base, n;
    reset = 1'b0;
    req_valid = 4'b0001;
    req_data = '0;
    tick();
    tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_core_operand", 64'(core_operand), 64'd0);
    req_valid = '0;
    reset = 1'b1;
    tick();
    // Single request: acceptance counted as cycle 1 puts the response at cycle 23.
    core_lat = 20;
    set_op(0, 32'h0008_0000);
    push(0, 32'h0002_0000, 1'b0, 22);
    req_valid = 4'b0001;
    drain(60);
    // Contention from a fresh pointer.
    do_reset();
    core_lat = 5;
    set_op(0, 32'h0008_0000);
    set_op(1, 32'h001B_0000);
    set_op(2, 32'h0040_0000);
    set_op(3, 32'h007D_0000);
    push(0, 32'h0002_0000, 1'b0, 7);
    push(1, 32'h0003_0000, 1'b0, 7);
    push(2, 32'h0004_0000, 1'b0, 7);
    push(3, 32'h0005_0000, 1'b0, 7);
    req_valid = 4'b1111;
    drain(200);
    // Fairness: 1 and 3 held valid alternate.
    do_reset();
    core_lat = 3;
    auto_drop = '0;
    set_op(1, 32'h03E8_0000);
    set_op(3, 32'h0040_0000);
    push(1, 32'h000A_0000, 1'b0, 5);
    push(3, 32'h0004_0000, 1'b0, 5);
    push(1, 32'h000A_0000, 1'b0, 5);
    push(3, 32'h0004_0000, 1'b0, 5);
    base = n_grants;
    req_valid = 4'b1010;
    n = 0;
    while (n_grants < base + 4 && n < 100) begin
      tick();
      n++;
    end
    req_valid = '0;
    auto_drop = '1;
    drain(50);
    // Reset during WAIT aborts; the late done is ignored and the pointer restarts at 0.
    core_lat = 12;
    set_op(2, 32'h001B_0000);
    exp_grant.push_back(2);
    base = n_grants;
    req_valid = 4'b0100;
    n = 0;
    while (n_grants == base && n < 20) begin
      tick();
      n++;
    end
    check("abort_grant_seen", 64'(n_grants - base), 64'd1);
    tick();
    tick();
    set_op(1, 32'h0008_0000);
    req_valid = 4'b0010;
    tick();
    check("busy_ready_low", 64'(req_ready), 64'd0);
    base = done_n;
    reset = 1'b0;
    tick();
    check("rst_mid_ready", 64'(req_ready), 64'd0);
    check("rst_mid_operand", 64'(core_operand), 64'd0);
    tick();
    req_valid = '0;
    reset = 1'b1;
    repeat (12) tick();
    check("late_done_seen", 64'(done_n - base), 64'd1);
    core_lat = 4;
    set_op(0, 32'h0008_0000);
    set_op(3, 32'h007D_0000);
    push(0, 32'h0002_0000, 1'b0, 6);
    push(3, 32'h0005_0000, 1'b0, 6);
    req_valid = 4'b1001;
    drain(60);
    // Stray done in IDLE.
    tick();
    rd = resp_data;
    co = core_operand;
    stray_n++;
    repeat (3) begin
      tick();
      check("stray_resp_valid", 64'(resp_valid), 64'd0);
      check("stray_core_start", 64'(core_start), 64'd0);
      check("stray_resp_data", 64'(resp_data), 64'(rd));
      check("stray_core_operand", 64'(core_operand), 64'(co));
    end
    set_op(1, 32'h0040_0000);
    push(1, 32'h0004_0000, 1'b0, 6);
    req_valid = 4'b0010;
    drain(40);
`ifdef CUBE_ROOT_ARB_TIMEOUT_EN
    core_hang = 1'b1;
    set_op(0, 32'h0008_0000);
    push(0, 32'h0000_0000, 1'b1, 66);
    req_valid = 4'b0001;
    drain(100);
    core_hang = 1'b0;
    set_op(2, 32'h001B_0000);
    push(2, 32'h0003_0000, 1'b0, 6);
    req_valid = 4'b0100;
    drain(40);
`endif
    repeat (3) tick();
    check("queues_empty", 64'(exp_resp.size() + exp_grant.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
